// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: bus widths, port identifiers
// and the request payload bundle.
package dmem_arbiter_pkg;

    typedef logic [31:0] u32_t;
    typedef logic [3:0]  wrstb_t;

    typedef enum logic {
        DMEM_PORT_CPU = 1'b0,
        DMEM_PORT_DMA = 1'b1
    } dmem_port_t;

    typedef struct packed {
        u32_t   addr;
        u32_t   wrdata;
        wrstb_t wrstb;
    } dmem_req_t;

    localparam logic [3:0] RUN_MAX = 4'hF;

    // An all-zero strobe pattern marks a read access.
    function automatic logic is_read(input wrstb_t stb);
        return stb == '0;
    endfunction

endpackage

// File: rtl/dmem_wrr_sel.sv
// Weighted round-robin selection between a CPU and a DMA requester.
// Purely combinational; the caller owns the CPU run counter.
module dmem_wrr_sel
    import dmem_arbiter_pkg::*;
#(
    parameter int CPU_WEIGHT = 3
) (
    input  logic       en,
    input  logic       c_req,
    input  logic       d_req,
    input  logic [3:0] c_run,
    output logic [1:0] gnt,        // [0] = CPU, [1] = DMA
    output logic       contended
);

    localparam logic [3:0] WEIGHT = 4'(CPU_WEIGHT);

    // NOTE: every output gets a default before the branches so no latch is inferred.
    always_comb begin
        gnt       = 2'b00;
        contended = en & c_req & d_req;
        if (en) begin
            if (c_req && d_req) begin
                if (c_run < WEIGHT) gnt = 2'b01;
                else                gnt = 2'b10;
            end else if (c_req) begin
                gnt = 2'b01;
            end else if (d_req) begin
                gnt = 2'b10;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port DMEM arbiter: CPU memory stage (C) and DMA/debug master (D) share
// one single-ported data memory; read responses are steered back by port.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int CPU_WEIGHT = 3
) (
    input  logic   clk,
    input  logic   rst,

    input  logic   c_req,
    input  u32_t   c_addr,
    input  u32_t   c_wrdata,
    input  wrstb_t c_wrstb,
    output logic   c_gnt,
    output logic   c_stall,
    output logic   c_rvalid,
    output u32_t   c_rddata,

    input  logic   d_req,
    input  u32_t   d_addr,
    input  u32_t   d_wrdata,
    input  wrstb_t d_wrstb,
    output logic   d_gnt,
    output logic   d_rvalid,
    output u32_t   d_rddata,

    output logic   dmem_en,
    output u32_t   dmem_addr,
    output u32_t   dmem_wrdata,
    output wrstb_t dmem_wrstb,
    input  u32_t   dmem_rddata
);

    logic [3:0] c_run_q, c_run_d;
    logic       rd_pend_q, rd_pend_d;
    dmem_port_t rd_port_q, rd_port_d;

    logic [1:0] gnt;
    logic       contended;
    dmem_req_t  c_bus, d_bus, sel_bus;

    assign c_bus = '{addr: c_addr, wrdata: c_wrdata, wrstb: c_wrstb};
    assign d_bus = '{addr: d_addr, wrdata: d_wrdata, wrstb: d_wrstb};

    // Grants are masked while reset is high so no access reaches DMEM.
    dmem_wrr_sel #(
        .CPU_WEIGHT (CPU_WEIGHT)
    ) u_sel (
        .en        (~rst),
        .c_req     (c_req),
        .d_req     (d_req),
        .c_run     (c_run_q),
        .gnt       (gnt),
        .contended (contended)
    );

    assign c_gnt   = gnt[0];
    assign d_gnt   = gnt[1];
    assign c_stall = c_req & ~c_gnt;

    always_comb begin
        sel_bus     = d_gnt ? d_bus : c_bus;
        dmem_en     = c_gnt | d_gnt;
        dmem_addr   = sel_bus.addr;
        dmem_wrdata = sel_bus.wrdata;
        dmem_wrstb  = dmem_en ? sel_bus.wrstb : '0;
    end

    always_comb begin
        c_run_d   = c_run_q;
        rd_pend_d = 1'b0;
        rd_port_d = rd_port_q;
        if (d_gnt) begin
            c_run_d = '0;
        end else if (c_gnt && contended && c_run_q != RUN_MAX) begin
            c_run_d = c_run_q + 4'd1;
        end
        if (dmem_en && is_read(sel_bus.wrstb)) begin
            rd_pend_d = 1'b1;
            rd_port_d = d_gnt ? DMEM_PORT_DMA : DMEM_PORT_CPU;
        end
    end

    // NOTE: state flops use non-blocking assignments; the asynchronous reset
    // drops any pending response immediately, not at the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_run_q   <= '0;
            rd_pend_q <= 1'b0;
            rd_port_q <= DMEM_PORT_CPU;
        end else begin
            c_run_q   <= c_run_d;
            rd_pend_q <= rd_pend_d;
            rd_port_q <= rd_port_d;
        end
    end

    assign c_rvalid = rd_pend_q & (rd_port_q == DMEM_PORT_CPU);
    assign d_rvalid = rd_pend_q & (rd_port_q == DMEM_PORT_DMA);
    assign c_rddata = dmem_rddata;
    assign d_rddata = dmem_rddata;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single-ported data memory between the CPU memory stage (port C) and the DMA/debug master (port D). It sits between the memory stage and DMEM, grants one access per cycle using weighted round-robin, and routes each read response to the port that issued the read. It also produces the memory-stage stall.

## Interface

Parameters:
- CPU_WEIGHT, 3: consecutive contended grants port C may take before port D is forced one grant; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- c_req  in  1  port C access request; held until granted.
- c_addr  in  u32_t  port C byte address.
- c_wrdata  in  u32_t  port C store data.
- c_wrstb  in  wrstb_t  port C byte strobes; '0 means read.
- c_gnt  out  1  port C access accepted this cycle.
- c_stall  out  1  c_req & ~c_gnt; freezes the memory stage and upstream stages.
- c_rvalid  out  1  port C read data valid.
- c_rddata  out  u32_t  port C read data.
- d_req, d_addr, d_wrdata, d_wrstb, d_gnt, d_rvalid, d_rddata: port D equivalents, same widths and meaning.
- dmem_en  out  1  DMEM access this cycle.
- dmem_addr  out  u32_t  DMEM address.
- dmem_wrdata  out  u32_t  DMEM write data.
- dmem_wrstb  out  wrstb_t  DMEM byte strobes.
- dmem_rddata  in  u32_t  DMEM read data, valid one cycle after a read with dmem_en=1.

## Operation

- Grants are combinational from requests and state. At most one grant per cycle. While rst is high, both grants, dmem_en and dmem_wrstb are 0.
- Only one requester active: that requester is granted.
- Both requesting (contended cycle): port C is granted while c_run < CPU_WEIGHT. Otherwise port D is granted.
- c_run is a 4-bit counter. On a contended C grant, c_run increments and saturates at 15. On any D grant, c_run clears. Uncontended C grants leave c_run unchanged.
- With CPU_WEIGHT=3, sustained contention gives the pattern C,C,C,D,C,C,C,D.
- Mux: the DMEM outputs carry the granted port's addr, wrdata and wrstb, and dmem_en=1. With no grant: dmem_en=0, dmem_wrstb='0, and addr/wrdata carry port C values.
- Read tracking: registers rd_pend (1 bit) and rd_port (0=C, 1=D). A granted access with wrstb=='0 sets rd_pend=1 and records rd_port. Otherwise rd_pend=0.
- c_rvalid = rd_pend & (rd_port==0); d_rvalid = rd_pend & (rd_port==1).
- c_rddata and d_rddata both equal dmem_rddata (unqualified); consumers must qualify with rvalid.
- Writes produce no response; a write is complete when granted.
- No exclusive or locked sequences. A requester must keep req and its payload stable until it is granted.

## Timing

- Reset values: c_run=0, rd_pend=0, rd_port=0. Hence c_rvalid=0 and d_rvalid=0.
- Grant latency is 0 cycles: a request is granted in the same cycle when uncontended.
- Read latency: a grant in cycle N gives rvalid in cycle N+1 with DMEM data. Back-to-back reads sustain 1 per cycle and may alternate ports.
- Worst-case wait for port D under contention: CPU_WEIGHT cycles. Worst-case wait for port C: 1 cycle.
- Write in cycle N followed by a read of the same address in N+1 returns the new data; this relies on DMEM write-then-read ordering.
- Reset asserted mid-read: the pending response is dropped and rvalid is 0 from reset assertion onward. c_run restarts at 0.
- A request that drops without being granted is legal for port D (abort); it has no effect on state.

## Structure

- Add to the shared types package: typedef dmem_port_t (enum DMEM_PORT_CPU=0, DMEM_PORT_DMA=1) for rd_port, and struct dmem_req_t {addr, wrdata, wrstb} so port payloads are passed as one bundle.
- Single module. The weighted round-robin selection logic (requests, c_run, CPU_WEIGHT in; grant vector out) is a natural sub-module named dmem_wrr_sel, reusable for a future IMEM/DMEM unified port.

## Test plan

- Reset: rst=1 with c_req=d_req=1 -> c_gnt=d_gnt=0, dmem_en=0, both rvalid=0. Release rst -> c_gnt=1 on the first edge-free cycle.
- Single CPU read: c_req=1, c_addr=0x100, c_wrstb=0, memory[0x100]=0xDEADBEEF -> c_gnt=1, dmem_addr=0x100, dmem_en=1 in cycle N; c_rvalid=1, c_rddata=0xDEADBEEF in N+1; d_rvalid=0.
- Sustained contention with CPU_WEIGHT=3, both requesting reads for 8 cycles -> grant sequence C,C,C,D,C,C,C,D; rvalid follows one cycle later on the matching port.
- Store: d_req=1, d_wrstb=4'b1111, d_addr=0x40, d_wrdata=0x12345678 -> dmem_wrstb=4'b1111, no d_rvalid. CPU reads 0x40 in the next cycle and gets 0x12345678.
- Stall: d_req held and c_run=3 with c_req=1 -> c_stall=1 for exactly one cycle, then c_gnt=1.
- Reset mid-read: port D read granted in cycle N, rst asserted in N before the edge -> d_rvalid stays 0, c_run=0 after release.
